// File: rtl/rx_serial_aligner.sv
// Serial-to-parallel receive aligner.
// Hunts a 1-bit MSB-first stream for the COM symbol and locks after
// LOCK_COUNT consecutive byte-aligned COMs. Once locked, it delivers each
// non-COM byte with a one-cycle valid strobe. COM bytes are idles and are
// dropped. Lock holds until reset; there is no unlock path.
//
// state   | meaning
// --------+--------------------------------------------------------------
// SEARCH  | checks every bit position for COM; no byte grid yet
// LOCKING | grid fixed by the first COM; counts consecutive aligned COMs
// LOCKED  | aligned; delivers non-COM bytes, COM bytes are idle
module rx_serial_aligner #(
  parameter logic [7:0]  COM_SYM    = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

  state_t      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  com_cnt_q, com_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;

  logic [7:0]  cand;
  logic        boundary;
  logic        cand_is_com;
  logic [3:0]  com_cnt_inc;

  // The byte completed by the current edge, including the bit being sampled.
  assign cand        = {sr_q[6:0], data_in};
  assign boundary    = (bit_cnt_q == 3'd7);
  assign cand_is_com = (cand == COM_SYM);
  assign com_cnt_inc = com_cnt_q + 4'd1;

  // Register bank; reset takes priority and discards any partial byte.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state logic: alignment hunt, lock qualification, and byte delivery.
  always_comb begin
    state_d   = state_q;
    sr_d      = cand;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;

    case (state_q)
      SEARCH: begin
        if (cand_is_com) begin
          // This edge ends a byte, so the next edge starts bit 0 of the grid.
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          state_d   = (LOCK_CNT4 == 4'd1) ? LOCKED : LOCKING;
        end
      end

      LOCKING: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (cand_is_com) begin
            com_cnt_d = com_cnt_inc;
            if (com_cnt_inc == LOCK_CNT4) begin
              state_d = LOCKED;
            end
          end else begin
            // The hunt restarts on the next edge. The failing byte is not
            // searched again.
            com_cnt_d = 4'd0;
            bit_cnt_d = 3'd0;
            state_d   = SEARCH;
          end
        end
      end

      LOCKED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary && !cand_is_com) begin
          data_d  = cand;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = (state_q == LOCKED);

endmodule

// File: tb/tb_rx_serial_aligner.sv
// Directed bench for rx_serial_aligner: reset, lock, failed lock, idles,
// false match, and reset while locked.
module tb_rx_serial_aligner;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int n_tests;
  int n_fail;

  rx_serial_aligner #(
    .COM_SYM   (8'hBC),
    .LOCK_COUNT(4)
  ) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one bit, let one rising edge pass, then settle past it.
  task automatic step(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Send one byte MSB first. Bits 1..7 must show no strobe and active==act_pre.
  // After bit 8, the strobe, data_out and active are checked against the
  // expected values.
  task automatic send_byte(input string tag, input logic [7:0] b,
                           input logic exp_v, input logic [7:0] exp_d,
                           input logic act_pre, input logic act_post);
    for (int i = 7; i >= 1; i--) begin
      step(b[i]);
      check({tag, " valid mid"}, 32'(valid_out), 32'(1'b0));
      check({tag, " active mid"}, 32'(active), 32'(act_pre));
    end
    step(b[0]);
    check({tag, " valid end"}, 32'(valid_out), 32'(exp_v));
    check({tag, " data end"}, 32'(data_out), 32'(exp_d));
    check({tag, " active end"}, 32'(active), 32'(act_post));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'($urandom_range(0, 1)));
      check({tag, " rst data"}, 32'(data_out), 32'h0);
      check({tag, " rst valid"}, 32'(valid_out), 32'h0);
      check({tag, " rst active"}, 32'(active), 32'h0);
    end
    reset = 1'b0;
  endtask

  // Four aligned COMs; active rises right after the last bit of the fourth.
  task automatic lock_up(input string tag);
    send_byte({tag, " com1"}, 8'hBC, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte({tag, " com2"}, 8'hBC, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte({tag, " com3"}, 8'hBC, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte({tag, " com4"}, 8'hBC, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    data_in = 1'b0;

    // 1: reset held with random data, then the first cycle after release.
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)));
      check("t1 rst data", 32'(data_out), 32'h0);
      check("t1 rst valid", 32'(valid_out), 32'h0);
      check("t1 rst active", 32'(active), 32'h0);
    end
    reset = 1'b0;
    step(1'b0);
    check("t1 post data", 32'(data_out), 32'h0);
    check("t1 post valid", 32'(valid_out), 32'h0);
    check("t1 post active", 32'(active), 32'h0);

    // 2: junk bits 1,0,1 then lock, then two data bytes 8 cycles apart.
    step(1'b1); check("t2 junk0 valid", 32'(valid_out), 32'h0);
    step(1'b0); check("t2 junk1 valid", 32'(valid_out), 32'h0);
    step(1'b1); check("t2 junk2 valid", 32'(valid_out), 32'h0);
    lock_up("t2");
    send_byte("t2 d12", 8'h12, 1'b1, 8'h12, 1'b1, 1'b1);
    send_byte("t2 d34", 8'h34, 1'b1, 8'h34, 1'b1, 1'b1);

    // 3: two COMs then 0x55 abandon the lock, then a full lock and 0xA5.
    do_reset("t3");
    send_byte("t3 com1", 8'hBC, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("t3 com2", 8'hBC, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("t3 bad55", 8'h55, 1'b0, 8'h00, 1'b0, 1'b0);
    lock_up("t3 relock");
    send_byte("t3 dA5", 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1);

    // 4: idles inside lock are dropped; data_out holds the last byte.
    do_reset("t4");
    lock_up("t4");
    send_byte("t4 d01", 8'h01, 1'b1, 8'h01, 1'b1, 1'b1);
    send_byte("t4 idle1", 8'hBC, 1'b0, 8'h01, 1'b1, 1'b1);
    send_byte("t4 idle2", 8'hBC, 1'b0, 8'h01, 1'b1, 1'b1);
    send_byte("t4 d02", 8'h02, 1'b1, 8'h02, 1'b1, 1'b1);

    // 5: 0B C0 hides a COM at bit offset 4; the next aligned byte is 0x00,
    // so the hunt restarts. A clean byte-grid lock must follow.
    do_reset("t5");
    send_byte("t5 b0B", 8'h0B, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("t5 bC0", 8'hC0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("t5 b00", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    lock_up("t5 relock");
    send_byte("t5 d3C", 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b1);

    // 6: reset at bit 4 of 0x77 while locked; 0x77 is never delivered, and
    // after release three COMs are not enough to lock.
    do_reset("t6");
    lock_up("t6");
    step(1'b0); step(1'b1); step(1'b1); step(1'b1);
    check("t6 pre-rst active", 32'(active), 32'h1);
    check("t6 pre-rst valid", 32'(valid_out), 32'h0);
    reset = 1'b1;
    step(1'b0);
    check("t6 rst data", 32'(data_out), 32'h0);
    check("t6 rst valid", 32'(valid_out), 32'h0);
    check("t6 rst active", 32'(active), 32'h0);
    reset = 1'b0;
    send_byte("t6 b77", 8'h77, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("t6 com1", 8'hBC, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("t6 com2", 8'hBC, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("t6 com3", 8'hBC, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("t6 d22 unlocked", 8'h22, 1'b0, 8'h00, 1'b0, 1'b0);
    lock_up("t6 relock");
    send_byte("t6 d22", 8'h22, 1'b1, 8'h22, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_serial_aligner.md
Name: rx_serial_aligner

Overview:
- Receive-side serial-to-parallel stage of phy_rx, sitting upstream of the L1/L2 demux chain.
- Takes a 1-bit serial stream, finds byte alignment by hunting for the COM symbol, and declares lock after consecutive aligned COMs.
- Once locked, emits each non-COM byte with a one-cycle valid strobe; COM bytes are treated as idle and dropped.

Parameters:
- COM_SYM, 8'hBC, alignment/idle symbol.
- LOCK_COUNT, 4, consecutive aligned COMs needed to lock (legal 1..15; includes the COM found in SEARCH).

Ports:
- clk_32f  input  1  serial bit clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial bit, MSB of each byte first, sampled every posedge.
- data_out  output  8  last delivered byte.
- valid_out  output  1  one-cycle strobe, data_out holds a new byte.
- active  output  1  high while in LOCKED.

Behaviour:
- Reset (sampled high at posedge):
  - data_out=0, valid_out=0, active=0.
  - Internal shift reg=0, bit_cnt=0, com_cnt=0, state=SEARCH.
  - Reset has priority over all other activity. Asserting it mid-byte or mid-lock discards partial data.
- Shift path:
  - Every posedge, sr <= {sr[6:0], data_in}.
  - cand = {sr[6:0], data_in} is the byte completed by the current edge.
- SEARCH:
  - Bit-by-bit compare of cand to COM_SYM on every edge.
  - On match: bit_cnt<=0, com_cnt<=1. Go to LOCKED if LOCK_COUNT==1, else LOCKING.
  - valid_out=0. data_out holds.
- Byte boundary (LOCKING/LOCKED):
  - bit_cnt increments 0..7 and wraps to 0.
  - The edge with bit_cnt==7 is a byte boundary; cand is the aligned byte.
- LOCKING, at a boundary:
  - cand==COM_SYM: com_cnt+1. If the new count equals LOCK_COUNT, go to LOCKED and active<=1 on the same edge.
  - cand!=COM_SYM: com_cnt<=0, back to SEARCH. The hunt resumes from the next edge; the failing byte is not re-searched.
  - No valid_out in LOCKING.
- LOCKED, at a boundary:
  - cand!=COM_SYM: data_out<=cand, valid_out<=1.
  - cand==COM_SYM: idle; valid_out<=0, data_out holds.
  - Lock persists until reset. There is no unlock path.
- valid_out:
  - High for exactly one cycle, following the edge that sampled a byte's 8th bit (latency 1 cycle after the last bit).
  - Otherwise 0. Minimum spacing between pulses is 8 cycles.
- active:
  - Rises in the cycle after the edge sampling the last bit of the LOCK_COUNT-th COM.
  - Stays high until reset.
- Simultaneous events: a boundary edge that completes lock produces no valid_out. The first data byte can appear only at the next boundary.
- Counter widths: bit_cnt 3 bits, com_cnt 4 bits. No saturation is needed because com_cnt stops at LOCK_COUNT.

Test Plan:
1. Reset: hold reset 3 cycles with random data_in -> data_out=0, valid_out=0, active=0 throughout and on the first cycle after release.
2. Lock and data: 3 junk bits, then 4×0xBC, 0x12, 0x34 -> active rises 1 cycle after the last bit of the 4th BC; valid_out pulses with 0x12, then 0x34 exactly 8 cycles later; no other pulses.
3. Failed lock: 2×0xBC, then 0x55 -> back to SEARCH, active stays 0, no valid_out. A following 4×0xBC then 0xA5 -> lock, then valid_out with 0xA5.
4. Idle in lock: after lock send 0x01, 0xBC, 0xBC, 0x02 -> exactly two valid_out pulses (0x01, 0x02), 24 cycles apart; data_out holds 0x01 across the idles.
5. False match: in SEARCH send 0x0B, 0xC0, 0x00 -> cand==0xBC at bit offset 4 enters LOCKING; the next aligned byte ≠ BC returns to SEARCH; active stays 0.
6. Reset mid-operation: while locked, assert reset at bit 4 of byte 0x77 -> next cycle all outputs 0, no 0x77 delivered; after release, data is ignored until 4 new aligned BCs.
